// File: rtl/regs_bus_arb.sv
// Two-master register-bus arbiter and sequencer.
// Round-robin arbitration in idle, single-cycle writes, and a 4-phase read
// handshake with a timeout so that a dead read source cannot stall a master.
module regs_bus_arb #(
  parameter int unsigned C_DAT_W = 8,
  parameter int unsigned C_ADR_W = 4,
  parameter int unsigned C_RD_TO = 200,
  parameter int unsigned C_TO_W  = 8
) (
  input  logic               CK_i,
  input  logic               RST_i,
  input  logic [C_ADR_W-1:0] M0_ADRs_i,
  input  logic [C_DAT_W-1:0] M0_WDATs_i,
  input  logic               M0_WT_REQ_i,
  input  logic               M0_RD_REQ_i,
  output logic               M0_ACK_o,
  input  logic [C_ADR_W-1:0] M1_ADRs_i,
  input  logic [C_DAT_W-1:0] M1_WDATs_i,
  input  logic               M1_WT_REQ_i,
  input  logic               M1_RD_REQ_i,
  output logic               M1_ACK_o,
  output logic [C_DAT_W-1:0] RDATs_o,
  output logic               ERR_o,
  output logic [C_ADR_W-1:0] ADRs_o,
  output logic [C_DAT_W-1:0] WDATs_o,
  output logic               WT_o,
  output logic               RD_REQ_o,
  input  logic               RD_ACK_i,
  input  logic [C_DAT_W-1:0] RDATs_i,
  output logic [1:0]         GNTs_o
);

  typedef enum logic [2:0] {StIdle, StWt, StRdWait, StRdRel, StDone, StErr} state_e;

  localparam logic [C_TO_W-1:0] ToLast = C_TO_W'(C_RD_TO - 1);

  state_e               state_q;
  logic                 last_q;
  logic [C_TO_W-1:0]    cnt_q;
  logic [1:0]           gnt_q;
  logic                 ack0_q, ack1_q, err_q, wt_q, rd_req_q;
  logic [C_ADR_W-1:0]   adr_q;
  logic [C_DAT_W-1:0]   wdat_q, rdat_q;

  logic                 req0, req1, grant1, sel_wt, to_last;
  logic [C_ADR_W-1:0]   sel_adr;
  logic [C_DAT_W-1:0]   sel_wdat;

  // Round-robin choice: on a tie the master that was not granted last wins.
  always_comb begin
    req0     = M0_WT_REQ_i | M0_RD_REQ_i;
    req1     = M1_WT_REQ_i | M1_RD_REQ_i;
    grant1   = req1 & (~req0 | ~last_q);
    sel_wt   = grant1 ? M1_WT_REQ_i : M0_WT_REQ_i;
    sel_adr  = grant1 ? M1_ADRs_i   : M0_ADRs_i;
    sel_wdat = grant1 ? M1_WDATs_i  : M0_WDATs_i;
    // >= rather than == so an acknowledge taken on the final wait cycle still
    // times out in release instead of letting the counter run on.
    to_last  = (cnt_q >= ToLast);
  end

  // Sequencer FSM with all bus and master outputs registered.
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      gnt_q    <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      wt_q     <= 1'b0;
      rd_req_q <= 1'b0;
      adr_q    <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
    end else begin
      wt_q   <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req0 | req1) begin
            last_q <= grant1;
            gnt_q  <= grant1 ? 2'b10 : 2'b01;
            adr_q  <= sel_adr;
            wdat_q <= sel_wdat;
            if (sel_wt) begin
              // Write wins when both write and read are requested.
              state_q <= StWt;
              wt_q    <= 1'b1;
              ack0_q  <= ~grant1;
              ack1_q  <= grant1;
            end else begin
              state_q  <= StRdWait;
              rd_req_q <= 1'b1;
              cnt_q    <= '0;
            end
          end
        end
        StRdWait: begin
          cnt_q <= cnt_q + C_TO_W'(1);
          if (RD_ACK_i) begin
            rdat_q   <= RDATs_i;
            rd_req_q <= 1'b0;
            state_q  <= StRdRel;
          end else if (to_last) begin
            rd_req_q <= 1'b0;
            rdat_q   <= '1;
            ack0_q   <= gnt_q[0];
            ack1_q   <= gnt_q[1];
            err_q    <= 1'b1;
            state_q  <= StErr;
          end
        end
        StRdRel: begin
          cnt_q <= cnt_q + C_TO_W'(1);
          if (!RD_ACK_i) begin
            ack0_q  <= gnt_q[0];
            ack1_q  <= gnt_q[1];
            state_q <= StDone;
          end else if (to_last) begin
            rdat_q  <= '1;
            ack0_q  <= gnt_q[0];
            ack1_q  <= gnt_q[1];
            err_q   <= 1'b1;
            state_q <= StErr;
          end
        end
        StWt, StDone, StErr: begin
          gnt_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign M0_ACK_o = ack0_q;
  assign M1_ACK_o = ack1_q;
  assign ERR_o    = err_q;
  assign WT_o     = wt_q;
  assign RD_REQ_o = rd_req_q;
  assign GNTs_o   = gnt_q;
  assign ADRs_o   = adr_q;
  assign WDATs_o  = wdat_q;
  assign RDATs_o  = rdat_q;

endmodule

// File: tb/tb_regs_bus_arb.sv
// Directed bench for regs_bus_arb: writes, reads, arbitration, timeout, reset.
module tb_regs_bus_arb;

  logic       ck = 1'b0;
  logic       rst;
  logic [3:0] m0_adr, m1_adr, adr;
  logic [7:0] m0_wdat, m1_wdat, wdat, rdat, rdat_in;
  logic       m0_wt, m0_rd, m0_ack, m1_wt, m1_rd, m1_ack;
  logic       err, wt, rd_req, rd_ack;
  logic [1:0] gnt;

  int total = 0;
  int bad   = 0;

  regs_bus_arb dut (
    .CK_i        (ck),
    .RST_i       (rst),
    .M0_ADRs_i   (m0_adr),
    .M0_WDATs_i  (m0_wdat),
    .M0_WT_REQ_i (m0_wt),
    .M0_RD_REQ_i (m0_rd),
    .M0_ACK_o    (m0_ack),
    .M1_ADRs_i   (m1_adr),
    .M1_WDATs_i  (m1_wdat),
    .M1_WT_REQ_i (m1_wt),
    .M1_RD_REQ_i (m1_rd),
    .M1_ACK_o    (m1_ack),
    .RDATs_o     (rdat),
    .ERR_o       (err),
    .ADRs_o      (adr),
    .WDATs_o     (wdat),
    .WT_o        (wt),
    .RD_REQ_o    (rd_req),
    .RD_ACK_i    (rd_ack),
    .RDATs_i     (rdat_in),
    .GNTs_o      (gnt)
  );

  always #5 ck = ~ck;

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_adr = '0; m0_wdat = '0; m0_wt = 1'b0; m0_rd = 1'b0;
    m1_adr = '0; m1_wdat = '0; m1_wt = 1'b0; m1_rd = 1'b0;
    rd_ack = 1'b0; rdat_in = '0;
    tick(); tick();
    total++; if ({m0_ack, m1_ack, err, wt, rd_req} !== 5'b0) begin
      bad++; $display("FAIL reset_ctl got=%b want=00000", {m0_ack, m1_ack, err, wt, rd_req});
    end
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b want=00", gnt); end
    total++; if ({adr, wdat, rdat} !== 20'h0) begin
      bad++; $display("FAIL reset_data got=%h want=00000", {adr, wdat, rdat});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    m0_adr = 4'h4; m0_wdat = 8'hA5; m0_wt = 1'b1;
    total++; if (wt !== 1'b0) begin bad++; $display("FAIL wr_early got=%b want=0", wt); end
    tick();
    total++; if ({wt, m0_ack, m1_ack} !== 3'b110) begin
      bad++; $display("FAIL wr_pulse got=%b want=110", {wt, m0_ack, m1_ack});
    end
    total++; if ({adr, wdat, gnt} !== {4'h4, 8'hA5, 2'b01}) begin
      bad++; $display("FAIL wr_bus got=%h/%h/%b want=4/a5/01", adr, wdat, gnt);
    end
    tick();
    m0_wt = 1'b0;
    total++; if ({wt, m0_ack, gnt} !== 4'b0) begin
      bad++; $display("FAIL wr_end got=%b want=0000", {wt, m0_ack, gnt});
    end
    tick();
  endtask

  task automatic test_read();
    int acks = 0;
    m1_adr = 4'hF; m1_rd = 1'b1;
    tick();
    total++; if ({rd_req, gnt, adr} !== {1'b1, 2'b10, 4'hF}) begin
      bad++; $display("FAIL rd_start got=%b/%b/%h want=1/10/f", rd_req, gnt, adr);
    end
    tick(); tick(); tick();
    rd_ack = 1'b1; rdat_in = 8'hBC;
    total++; if (rd_req !== 1'b1) begin bad++; $display("FAIL rd_hold got=%b want=1", rd_req); end
    tick();
    rdat_in = 8'h00;
    total++; if ({rd_req, rdat} !== {1'b0, 8'hBC}) begin
      bad++; $display("FAIL rd_capture got=%b/%h want=0/bc", rd_req, rdat);
    end
    for (int i = 0; i < 2; i++) begin
      acks += int'(m1_ack) + int'(m0_ack);
      tick();
    end
    rd_ack = 1'b0;
    acks += int'(m1_ack) + int'(m0_ack);
    total++; if (acks != 0) begin bad++; $display("FAIL rd_ack_early got=%0d want=0", acks); end
    tick();
    total++; if ({m1_ack, m0_ack, err, rdat} !== {3'b100, 8'hBC}) begin
      bad++; $display("FAIL rd_done got=%b%b%b/%h want=100/bc", m1_ack, m0_ack, err, rdat);
    end
    tick();
    m1_rd = 1'b0;
    total++; if ({m1_ack, gnt} !== 3'b0) begin
      bad++; $display("FAIL rd_end got=%b want=000", {m1_ack, gnt});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n = 0, last_ack = -1, cyc = 0, max_gap = 0;
    logic [5:0] order = '0;
    logic       adr_bad = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    m0_adr = 4'h1; m0_wdat = 8'h11; m0_wt = 1'b1;
    m1_adr = 4'h2; m1_wdat = 8'h22; m1_wt = 1'b1;
    while (n < 6 && cyc < 40) begin
      tick();
      cyc++;
      if (m0_ack || m1_ack) begin
        order[n] = m1_ack;
        if (adr !== (m1_ack ? 4'h2 : 4'h1)) adr_bad = 1'b1;
        if (last_ack >= 0 && cyc - last_ack - 1 > max_gap) max_gap = cyc - last_ack - 1;
        last_ack = cyc;
        n++;
      end
    end
    tick();
    m0_wt = 1'b0; m1_wt = 1'b0;
    total++; if (n != 6) begin bad++; $display("FAIL b2b_count got=%0d want=6", n); end
    total++; if (order !== 6'b101010) begin
      bad++; $display("FAIL b2b_order got=%b want=101010 (bit0 first, 1=M1)", order);
    end
    total++; if (max_gap > 1) begin bad++; $display("FAIL b2b_gap got=%0d want<=1", max_gap); end
    total++; if (adr_bad) begin bad++; $display("FAIL b2b_adr got=mismatched want=per-master"); end
    tick(); tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    logic early = 1'b0;
    m0_adr = 4'h3; m0_rd = 1'b1; rd_ack = 1'b0;
    tick();
    while (rd_req && n < 300) begin
      if (m0_ack || err) early = 1'b1;
      n++;
      tick();
    end
    total++; if (n != 200) begin bad++; $display("FAIL to_len got=%0d want=200", n); end
    total++; if (early) begin bad++; $display("FAIL to_early got=ack want=none"); end
    total++; if ({m0_ack, err, rdat, gnt} !== {2'b11, 8'hFF, 2'b01}) begin
      bad++; $display("FAIL to_err got=%b%b/%h/%b want=11/ff/01", m0_ack, err, rdat, gnt);
    end
    tick();
    m0_rd = 1'b0;
    total++; if ({m0_ack, err} !== 2'b00) begin
      bad++; $display("FAIL to_end got=%b want=00", {m0_ack, err});
    end
    m1_adr = 4'h5; m1_wdat = 8'h3C; m1_wt = 1'b1;
    tick();
    total++; if ({wt, m1_ack, adr, wdat, rdat} !== {2'b11, 4'h5, 8'h3C, 8'hFF}) begin
      bad++; $display("FAIL to_next got=%b%b/%h/%h/%h want=11/5/3c/ff", wt, m1_ack, adr, wdat, rdat);
    end
    tick();
    m1_wt = 1'b0;
    tick();
  endtask

  task automatic test_ack_early();
    int n = 0;
    m0_adr = 4'h6; m0_rd = 1'b1; rd_ack = 1'b1; rdat_in = 8'h5A;
    tick();
    total++; if (rd_req !== 1'b1) begin bad++; $display("FAIL ae_req got=%b want=1", rd_req); end
    tick();
    total++; if ({rd_req, rdat} !== {1'b0, 8'h5A}) begin
      bad++; $display("FAIL ae_capture got=%b/%h want=0/5a", rd_req, rdat);
    end
    rd_ack = 1'b0;
    tick();
    total++; if ({m0_ack, err, rdat} !== {2'b10, 8'h5A}) begin
      bad++; $display("FAIL ae_done got=%b%b/%h want=10/5a", m0_ack, err, rdat);
    end
    tick();
    rd_ack = 1'b1; rdat_in = 8'h12;
    tick();
    // Stuck-high acknowledge: accepted at once, then release never completes.
    while (!m0_ack && n < 300) begin n++; tick(); end
    total++; if (n != 200) begin bad++; $display("FAIL stuck_len got=%0d want=200", n); end
    total++; if ({err, rdat} !== {1'b1, 8'hFF}) begin
      bad++; $display("FAIL stuck_err got=%b/%h want=1/ff", err, rdat);
    end
    tick();
    m0_rd = 1'b0; rd_ack = 1'b0;
    tick();
  endtask

  task automatic test_early_drop();
    m1_adr = 4'h2; m1_rd = 1'b1;
    tick();
    m1_rd = 1'b0;
    tick();
    rd_ack = 1'b1; rdat_in = 8'h77;
    tick();
    rd_ack = 1'b0;
    tick();
    total++; if ({m1_ack, rdat} !== {1'b1, 8'h77}) begin
      bad++; $display("FAIL drop_done got=%b/%h want=1/77", m1_ack, rdat);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    m0_adr = 4'h7; m0_rd = 1'b1;
    tick(); tick();
    total++; if (rd_req !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b want=1", rd_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0; m0_rd = 1'b0;
    total++; if ({rd_req, gnt} !== 3'b000) begin
      bad++; $display("FAIL rm_clear got=%b/%b want=0/00", rd_req, gnt);
    end
    for (int i = 0; i < 3; i++) begin
      acks += int'(m0_ack) + int'(m1_ack);
      tick();
    end
    total++; if (acks != 0) begin bad++; $display("FAIL rm_noack got=%0d want=0", acks); end
    m0_adr = 4'hA; m0_wdat = 8'h11; m0_wt = 1'b1;
    m1_adr = 4'hB; m1_wdat = 8'h22; m1_wt = 1'b1;
    tick();
    m0_wt = 1'b0; m1_wt = 1'b0;
    total++; if ({gnt, m0_ack, adr} !== {2'b01, 1'b1, 4'hA}) begin
      bad++; $display("FAIL rm_tie got=%b/%b/%h want=01/1/a", gnt, m0_ack, adr);
    end
    tick(); tick();
  endtask

  task automatic test_wt_rd_both();
    int wts = 0, acks = 0, rds = 0;
    logic [11:0] bus = '0;
    m0_adr = 4'h8; m0_wdat = 8'h30; m0_wt = 1'b1; m0_rd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wt) bus = {adr, wdat};
      wts  += int'(wt);
      acks += int'(m0_ack);
      rds  += int'(rd_req);
      if (m0_ack) begin m0_wt = 1'b0; m0_rd = 1'b0; end
    end
    total++; if (wts != 1) begin bad++; $display("FAIL both_wt got=%0d want=1", wts); end
    total++; if (acks != 1) begin bad++; $display("FAIL both_ack got=%0d want=1", acks); end
    total++; if (rds != 0) begin bad++; $display("FAIL both_rd got=%0d want=0", rds); end
    total++; if (bus !== 12'h830) begin bad++; $display("FAIL both_bus got=%h want=830", bus); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_ack_early();
    test_early_drop();
    test_reset_mid();
    test_wt_rd_both();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regs_bus_arb.md
Name: regs_bus_arb

Overview:
- Two-master arbiter and sequencer for the register bus.
- The bus carries the address, write data, single-cycle write strobe and 4-phase read handshake that connect the UART command parser to the register file and the read-back sources.
- Master 0 is the UART parser; master 1 is an internal sequencer, e.g. a frame-sync register loader.
- The block serialises both masters onto one slave bus with round-robin fairness. It also runs the read handshake with a timeout, so a dead read source cannot hang the UART link.

Parameters:
- C_DAT_W, 8: data width of the register bus.
- C_ADR_W, 4: address width of the register bus.
- C_RD_TO, 200: read-handshake timeout in CK_i cycles, counted from the first cycle RD_REQ_o is high. Must be at least 4.
- C_TO_W, 8: width of the timeout counter. Must satisfy 2**C_TO_W > C_RD_TO.

Ports:
- CK_i  in  1  single clock; every flop is updated on its rising edge.
- RST_i  in  1  reset; synchronous, active-high.
- M0_ADRs_i  in  C_ADR_W  master 0 address; held stable while a request is high.
- M0_WDATs_i  in  C_DAT_W  master 0 write data; held stable while a request is high.
- M0_WT_REQ_i  in  1  master 0 write request; level, held until M0_ACK_o.
- M0_RD_REQ_i  in  1  master 0 read request; level, held until M0_ACK_o.
- M0_ACK_o  out  1  one-cycle completion pulse to master 0.
- M1_ADRs_i, M1_WDATs_i, M1_WT_REQ_i, M1_RD_REQ_i, M1_ACK_o: same as the M0 ports, for master 1.
- RDATs_o  out  C_DAT_W  read data; valid in the ACK cycle; holds until the next read completes.
- ERR_o  out  1  high together with ACK when the read timed out.
- ADRs_o  out  C_ADR_W  slave address; registered at grant.
- WDATs_o  out  C_DAT_W  slave write data; registered at grant.
- WT_o  out  1  one-cycle slave write strobe.
- RD_REQ_o  out  1  slave read request; 4-phase handshake.
- RD_ACK_i  in  1  slave read acknowledge.
- RDATs_i  in  C_DAT_W  slave read data; sampled in the cycle RD_ACK_i is first seen high.
- GNTs_o  out  2  one-hot current grant; 00 when idle.

Behaviour:
Reset:
- RST_i high forces state IDLE and drives every output to 0, including RD_REQ_o, RDATs_o and GNTs_o.
- The round-robin pointer LAST is set to 1, so master 0 wins the first tie.
- Reset mid-transaction aborts the transaction; no ACK is issued for it.

Request and arbitration:
- REQn = Mn_WT_REQ_i | Mn_RD_REQ_i.
- Arbitration happens in IDLE only.
- One requester: it is granted.
- Both requesting: the master that is not LAST is granted.
- On grant, LAST is set to the granted master, and ADRs_o, WDATs_o and GNTs_o are registered.
- If a master asserts WT and RD together, a write is performed. The read is ignored.

States:
- IDLE
  - No request: stay in IDLE.
  - Grant with write: go to WT.
  - Grant with read: go to RD_WAIT.
- WT (1 cycle)
  - WT_o = 1 and Mn_ACK_o = 1.
  - Go to IDLE.
  - Write latency: request seen in IDLE cycle N; WT_o and ACK are high in N+1.
- RD_WAIT
  - RD_REQ_o = 1; the timeout counter starts at 0 on entry and increments every cycle.
  - RD_ACK_i high: capture RDATs_i into RDATs_o, drop RD_REQ_o (next cycle 0), go to RD_REL.
- RD_REL
  - RD_REQ_o = 0; the counter keeps running.
  - RD_ACK_i low: go to DONE.
- DONE (1 cycle)
  - Mn_ACK_o = 1, ERR_o = 0.
  - Go to IDLE.
- ERR (1 cycle)
  - Entered from RD_WAIT or RD_REL when the counter equals C_RD_TO-1 and that state's exit condition is false.
  - RD_REQ_o = 0, RDATs_o = all ones, Mn_ACK_o = 1, ERR_o = 1.
  - Go to IDLE.

Master handshake rules:
- The ACK pulse is exactly one cycle, and only to the granted master.
- Registered masters drop their request the cycle after ACK. IDLE in the following cycle must therefore see the request low; no extra guard cycle is added.
- GNTs_o returns to 00 in the cycle after ACK.
- Back-to-back: a pending request from the other master is granted in the IDLE cycle immediately after ACK. Sustained contention therefore alternates M0, M1, M0, and so on.

Boundary cases:
- RD_ACK_i already high on entry to RD_WAIT: accepted in the first RD_WAIT cycle.
- RD_ACK_i stuck high: times out in RD_REL; ERR is reported.
- Request deasserted before ACK (protocol violation): the transaction still completes and ACK is still pulsed.
- Both masters' requests rise in the same cycle as the previous ACK: resolved in the next IDLE cycle by LAST.

Test Plan:
1. Reset, then M0 writes ADR=4, WDAT=A5 → WT_o high for exactly 1 cycle, 1 cycle after the request is sampled; ADRs_o=4, WDATs_o=A5, M0_ACK_o in the same cycle, GNTs_o=01.
2. M1 reads ADR=F; slave raises RD_ACK_i 3 cycles after RD_REQ_o with RDATs_i=BC, then drops it 2 cycles after RD_REQ_o falls → RDATs_o=BC, M1_ACK_o 1 cycle after RD_ACK_i falls, ERR_o=0.
3. M0 and M1 both write continuously from reset, 6 transactions → grant order M0, M1, M0, M1, M0, M1; no idle gap longer than 1 cycle between ACKs.
4. Read with RD_ACK_i held at 0, C_RD_TO=200 → RD_REQ_o high exactly 200 cycles, then ERR state: ACK and ERR_o high, RDATs_o=FF; the next request is served normally.
5. RST_i pulsed while in RD_WAIT → RD_REQ_o=0 and GNTs_o=00 in the next cycle; no ACK issued; LAST=1 (M0 wins the next tie).
6. M0 asserts WT_REQ and RD_REQ together (ADR=8, WDAT=30) → single WT_o pulse; RD_REQ_o stays 0; M0_ACK_o pulses once.
